cordic_prenorm: RTL and testbench

Parametrised front-end for the CORDIC pipeline: accepts an integer-degree angle (rotation mode) or an (x, y) vector (vectoring mode) and folds it into the core's convergence range. It emits fixed-point x/y/angle operands plus a 2-bit quadrant tag that the post-correction stage uses to restore sign and swap. It sits between the request source and the first CORDIC iteration stage, with valid/ready handshakes on both sides.

---
 rtl/cordic_prenorm_if.sv | 34 +++
 rtl/cordic_prenorm.sv | 143 ++++++++++++++
 tb/tb_cordic_prenorm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cordic_prenorm_if.sv
// Handshake and operand bundle between the request source, cordic_prenorm and
// the first CORDIC iteration stage.
interface cordic_prenorm_if #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned SEL_W  = 4
);
  localparam int unsigned W = IN_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_angle;
  logic [IN_W-1:0]  another;
  logic [SEL_W-1:0] select;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic [W-1:0]     out_angle;
  logic [1:0]       quad;
  logic [SEL_W-1:0] select_out;

  // Request source / result sink side.
  modport master (
    output in_valid, in_angle, another, select, out_ready,
    input  in_ready, out_valid, x, y, out_angle, quad, select_out
  );

  // Pre-normaliser side.
  modport slave (
    input  in_valid, in_angle, another, select, out_ready,
    output in_ready, out_valid, x, y, out_angle, quad, select_out
  );
endinterface

// File: rtl/cordic_prenorm.sv
// CORDIC front-end: folds an integer-degree angle into 0..89 with a quadrant
// tag (rotation), or mirrors a left-half-plane vector into the right half
// (vectoring), and presents fixed-point operands to the iteration pipeline.
module cordic_prenorm #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned QBITS  = IN_W - 6
) (
  input logic             clk,
  input logic             rst,
  cordic_prenorm_if.slave bus
);
  localparam int unsigned W  = IN_W + FRAC_W;
  localparam int unsigned KW = (QBITS > 1) ? $clog2(QBITS) : 1;
  // 90 < 2^7, so 90<<k always fits in IN_W+7 bits.
  localparam int unsigned DW = IN_W + 7;
  localparam logic [KW-1:0]   KTop = KW'(QBITS - 1);
  localparam logic [IN_W-1:0] SMin = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] SMax = {1'b0, {(IN_W-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StFold, StOut} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IN_W-1:0]  rem_q, rem_d;
  logic             q1_q, q1_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     ang_q, ang_d;
  logic [1:0]       quad_q, quad_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic            in_ready;
  logic            accept;
  logic [DW-1:0]   trial;
  logic            fits;
  logic [IN_W-1:0] rem_step;

  // Two's-complement negate; the most negative value clips to max positive.
  function automatic logic [IN_W-1:0] sat_neg(input logic [IN_W-1:0] v);
    return (v == SMin) ? SMax : (~v + IN_W'(1));
  endfunction

  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = bus.in_valid && in_ready;

  // One restoring-division step against 90<<k.
  assign trial    = DW'(90) << k_q;
  assign fits     = {7'b0, rem_q} >= trial;
  assign rem_step = fits ? (rem_q - trial[IN_W-1:0]) : rem_q;

  // Next-state and operand capture/fold logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    q1_d    = q1_q;
    x_d     = x_q;
    y_d     = y_q;
    ang_d   = ang_q;
    quad_d  = quad_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d = bus.select;
          if (bus.select[3]) begin
            ang_d   = '0;
            state_d = StOut;
            if (bus.in_angle[IN_W-1]) begin
              x_d    = {sat_neg(bus.in_angle), {FRAC_W{1'b0}}};
              y_d    = {sat_neg(bus.another), {FRAC_W{1'b0}}};
              quad_d = 2'd2;
            end else begin
              x_d    = {bus.in_angle, {FRAC_W{1'b0}}};
              y_d    = {bus.another, {FRAC_W{1'b0}}};
              quad_d = 2'd0;
            end
          end else begin
            rem_d   = bus.in_angle;
            k_d     = KTop;
            q1_d    = 1'b0;
            state_d = StFold;
          end
        end
      end
      StFold: begin
        rem_d = rem_step;
        k_d   = k_q - KW'(1);
        if (k_q == KW'(1)) begin
          q1_d = fits;
        end
        if (k_q == '0) begin
          x_d     = W'(1) << FRAC_W;
          y_d     = '0;
          ang_d   = {rem_step, {FRAC_W{1'b0}}};
          quad_d  = {q1_q, fits};
          state_d = StOut;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      rem_q   <= '0;
      q1_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ang_q   <= '0;
      quad_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      q1_q    <= q1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ang_q   <= ang_d;
      quad_q  <= quad_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == StOut);
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.out_angle  = ang_q;
  assign bus.quad       = quad_q;
  assign bus.select_out = sel_q;
endmodule

// File: tb/tb_cordic_prenorm.sv
// Directed bench for cordic_prenorm: rotation folds, vectoring mirror and
// saturation, backpressure, mid-fold reset, and select pass-through.
module tb_cordic_prenorm;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  int   seen;
  logic [31:0] hold_x;

  always #5 clk = ~clk;

  cordic_prenorm_if #(.IN_W(16), .FRAC_W(16), .SEL_W(4)) bus ();

  cordic_prenorm #(.IN_W(16), .FRAC_W(16), .SEL_W(4), .QBITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for the result, check it, complete the handshake.
  task automatic xact(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] sel, input int lat, input logic [31:0] ex,
                      input logic [31:0] ey, input logic [31:0] ea, input logic [1:0] eq);
    bus.in_valid = 1'b1;
    bus.in_angle = a;
    bus.another  = b;
    bus.select   = sel;
    step();
    bus.in_valid = 1'b0;
    bus.in_angle = 16'hFFFF;
    bus.another  = 16'h1234;
    bus.select   = 4'h0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_x"}, bus.x, ex);
    chk({tag, "_y"}, bus.y, ey);
    chk({tag, "_ang"}, bus.out_angle, ea);
    chk({tag, "_quad"}, {30'd0, bus.quad}, {30'd0, eq});
    chk({tag, "_sel"}, {28'd0, bus.select_out}, {28'd0, sel});
    step();
    chk({tag, "_done"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_angle  = '0;
    bus.another   = '0;
    bus.select    = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_x", bus.x, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Rotation folds: 135=1*90+45, 359=3*90+89, 450=5*90, 65535=728*90+15.
    xact("rot0", 16'd0, 16'd0, 4'b0000, 11, 32'h0001_0000, 32'd0, 32'd0, 2'd0);
    xact("rot135", 16'd135, 16'd0, 4'b0101, 11, 32'h0001_0000, 32'd0, 32'h002D_0000, 2'd1);
    xact("rot359", 16'd359, 16'd0, 4'b0000, 11, 32'h0001_0000, 32'd0, 32'h0059_0000, 2'd3);
    xact("rot450", 16'd450, 16'd0, 4'b0000, 11, 32'h0001_0000, 32'd0, 32'd0, 2'd1);
    xact("rot65535", 16'hFFFF, 16'd0, 4'b0000, 11, 32'h0001_0000, 32'd0, 32'h000F_0000,
         2'd0);

    // Vectoring: mirror, saturation of -32768, and pass-through of positive x.
    xact("vecneg", 16'hFFFD, 16'd4, 4'b1010, 1, 32'h0003_0000, 32'hFFFC_0000, 32'd0, 2'd2);
    xact("vecsat", 16'h8000, 16'h8000, 4'b1000, 1, 32'h7FFF_0000, 32'h7FFF_0000, 32'd0,
         2'd2);
    xact("vecpos", 16'd5, 16'hFFF9, 4'b1000, 1, 32'h0005_0000, 32'hFFF9_0000, 32'd0, 2'd0);

    // Backpressure: hold the result, keep a second request pending.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_angle  = 16'd3;
    bus.another   = 16'd2;
    bus.select    = 4'b1000;
    step();
    bus.in_angle  = 16'd90;
    bus.another   = 16'd0;
    bus.select    = 4'b0000;
    hold_x        = bus.x;
    chk("bp_x0", hold_x, 32'h0003_0000);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid && !bus.in_ready && bus.x === hold_x && bus.y === 32'h0002_0000) begin
        seen++;
      end
      step();
    end
    chk("bp_stable", seen, 5);
    bus.out_ready = 1'b1;
    step();
    chk("bp_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp2_lat", n, 11);
    chk("bp2_quad", {30'd0, bus.quad}, 32'd1);
    chk("bp2_ang", bus.out_angle, 32'd0);
    step();

    // Reset on the 4th fold cycle, with in_valid also high: nothing survives.
    bus.in_valid = 1'b1;
    bus.in_angle = 16'd200;
    bus.select   = 4'b0000;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    step();
    chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mrst_outs", {bus.x | bus.y | bus.out_angle}, 32'd0);
    chk("mrst_tags", {26'd0, bus.quad, bus.select_out}, 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mrst_ready_after", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    chk("mrst_no_valid", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
